// File: rtl/axis_tx_pkt_fifo.sv
// ----------------------------------------------------------------------------
// axis_tx_pkt_fifo
//
// Store-and-forward packet FIFO for the CASPER TX AXIS path, placed directly
// upstream of the 400G AXIS-to-DCMAC adapter. A packet becomes visible
// downstream only once its tlast beat has been accepted, so the adapter never
// sees a frame stall mid-way. Errored packets (tuser=1 on tlast) and packets
// that do not fit in the buffer are discarded rather than back-pressured.
//
// Handshake: a beat transfers on any rising clk edge where tvalid and tready
// are both 1. The master side holds tdata/tkeep/tlast stable while tvalid=1
// and tready=0. tvalid never depends on tready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_axis_tdata/tkeep/tvalid/
//   s_axis_tlast/tuser/tready     AXIS slave from CASPER TX (tuser = error,
//                                 only meaningful on the tlast beat)
//   m_axis_tdata/tkeep/tvalid/
//   m_axis_tlast/tuser/tready     AXIS master to the adapter (tuser always 0)
//   pkt_count                     committed packets, wraps mod 2^32
//   drop_count                    dropped packets, wraps mod 2^32
//   fifo_level                    registered occupancy in beats, including
//                                 beats of the packet still being written
// ----------------------------------------------------------------------------
module axis_tx_pkt_fifo #(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic [31:0]             pkt_count,
    output logic [31:0]             drop_count,
    output logic [ADDR_W:0]         fifo_level
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic {ST_ACCEPT = 1'b0, ST_DROP = 1'b1} state_t;

    // Beat storage; no reset needed, validity is tracked by the pointers.
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [KEEP_W-1:0]     r_mem_keep [DEPTH];
    logic                  r_mem_last [DEPTH];

    state_t          r_state, w_state_nxt;
    logic            r_s_ready;
    logic [ADDR_W:0] r_wr_commit, r_wr_cur, r_rd_ptr, r_fetch, r_commit_rd;
    logic [ADDR_W:0] w_wr_cur_nxt, w_rd_ptr_nxt, w_occ;
    logic [31:0]     r_pkt_count, r_drop_count;
    logic [ADDR_W:0] r_level;
    logic            w_beat, w_full;
    logic            w_store, w_commit, w_rollback, w_drop;
    logic            w_pop, w_load;
    logic            r_out_valid, r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_W-1:0]     r_out_keep;

    assign w_beat = s_axis_tvalid & r_s_ready;
    // Occupancy counts from rd_ptr before this edge: a beat popped this cycle
    // is not reusable until the next one.
    assign w_occ  = r_wr_cur - r_rd_ptr;
    assign w_full = (w_occ == FULL_LVL);

    // ---------------- write FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ACCEPT;
        else     r_state <= w_state_nxt;
    end

    // ---------------- write FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCEPT: if (w_beat && w_full && !s_axis_tlast) w_state_nxt = ST_DROP;
            ST_DROP:   if (w_beat && s_axis_tlast)            w_state_nxt = ST_ACCEPT;
            default:   w_state_nxt = ST_ACCEPT;
        endcase
    end

    // ---------------- write FSM: outputs ----------------
    // Overflow takes priority over the error flag: either way the packet is
    // rolled back to the last commit point and counted once.
    always_comb begin
        w_store    = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        w_drop     = 1'b0;
        if (r_state == ST_ACCEPT && w_beat) begin
            if (w_full || (s_axis_tlast && s_axis_tuser)) begin
                w_rollback = 1'b1;
                w_drop     = 1'b1;
            end else begin
                w_store  = 1'b1;
                w_commit = s_axis_tlast;
            end
        end
    end

    always_comb begin
        w_wr_cur_nxt = r_wr_cur;
        if (w_rollback)   w_wr_cur_nxt = r_wr_commit;
        else if (w_store) w_wr_cur_nxt = r_wr_cur + PTR_ONE;
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_data[r_wr_cur[ADDR_W-1:0]] <= s_axis_tdata;
            r_mem_keep[r_wr_cur[ADDR_W-1:0]] <= s_axis_tkeep;
            r_mem_last[r_wr_cur[ADDR_W-1:0]] <= s_axis_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_ready    <= 1'b0;
            r_wr_commit  <= '0;
            r_wr_cur     <= '0;
            r_rd_ptr     <= '0;
            r_commit_rd  <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_level      <= '0;
        end else begin
            r_s_ready   <= 1'b1;
            r_wr_cur    <= w_wr_cur_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            if (w_commit) r_wr_commit <= r_wr_cur + PTR_ONE;
            // The read side sees commits one cycle late, which gives the
            // two-cycle commit-to-tvalid latency.
            r_commit_rd <= r_wr_commit;
            if (w_commit) r_pkt_count  <= r_pkt_count + 32'd1;
            if (w_drop)   r_drop_count <= r_drop_count + 32'd1;
            r_level     <= w_wr_cur_nxt - w_rd_ptr_nxt;
        end
    end

    // ---------------- read side ----------------
    // The output register holds a copy of the beat at rd_ptr; that slot stays
    // counted in the occupancy until the handshake. r_fetch runs one ahead of
    // rd_ptr while the output register is full.
    assign w_pop  = r_out_valid & m_axis_tready;
    assign w_load = (!r_out_valid || w_pop) && (r_fetch != r_commit_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_fetch     <= r_fetch + PTR_ONE;
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem_data[r_fetch[ADDR_W-1:0]];
            r_out_keep  <= r_mem_keep[r_fetch[ADDR_W-1:0]];
            r_out_last  <= r_mem_last[r_fetch[ADDR_W-1:0]];
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = 1'b0;
    assign pkt_count     = r_pkt_count;
    assign drop_count    = r_drop_count;
    assign fifo_level    = r_level;

endmodule

// File: doc/axis_tx_pkt_fifo.md
Name: axis_tx_pkt_fifo

Overview:
- Store-and-forward packet FIFO on the 1024-bit CASPER TX AXIS path, directly upstream of the 400G AXIS-to-DCMAC adapter.
- Releases a packet downstream only after its last beat has been accepted, so the DCMAC segmented TX interface never underruns mid-frame.
- Discards errored packets (tuser=1 on tlast) and packets that overflow buffer capacity.
- Exposes packet, drop and level status.

Parameters:
- DATA_WIDTH, 1024, AXIS data width in bits; tkeep width is DATA_WIDTH/8.
- DEPTH, 256, buffer capacity in beats, power of 2. Capacity includes any output staging register.
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH  input data from CASPER TX
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tuser  in  1  error flag, sampled only on the tlast beat
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  output data to adapter
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  output last beat
- m_axis_tuser  out  1  always 0
- m_axis_tready  in  1  downstream ready
- pkt_count  out  32  committed packets, wraps modulo 2^32
- drop_count  out  32  dropped packets, wraps modulo 2^32
- fifo_level  out  ADDR_W+1  occupancy in beats, including uncommitted beats

Behaviour:
- Reset (synchronous; holds whenever rst=1):
  - All pointers, counters and the state machine return to zero/ACCEPT.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, pkt_count=0, drop_count=0, fifo_level=0.
  - s_axis_tready goes to 1 on the first clock edge after rst deasserts, and stays 1 from then on. Overflow is handled by dropping, never by backpressure.
  - Reset mid-packet discards all stored and partial data with no drop_count increment.
- Write pointers:
  - wr_ptr_commit: end of the last committed packet.
  - wr_ptr_cur: speculative write position.
  - rd_ptr: advances only on an m_axis handshake.
  - Occupancy = wr_ptr_cur - rd_ptr (ADDR_W+1 bits). fifo_level is this value, registered.
- Write FSM states: ACCEPT, DROP.
- ACCEPT, beat accepted (s_axis_tvalid & s_axis_tready):
  - Occupancy == DEPTH: overflow. Set wr_ptr_cur <= wr_ptr_commit and increment drop_count. If the beat is not tlast, go to DROP; if it is tlast, stay in ACCEPT.
  - Else if tlast & tuser: do not store. Set wr_ptr_cur <= wr_ptr_commit, increment drop_count.
  - Else if tlast & !tuser: store the beat. Set wr_ptr_commit <= wr_ptr_cur+1 and wr_ptr_cur <= wr_ptr_cur+1, increment pkt_count.
  - Else: store the beat (tdata, tkeep, tlast) and set wr_ptr_cur <= wr_ptr_cur+1.
- DROP:
  - Discard every beat.
  - On tlast, return to ACCEPT with no further drop_count increment.
- Packets longer than DEPTH beats are always dropped.
- Read side:
  - Data is available only when rd_ptr != wr_ptr_commit, so only whole committed packets are ever visible.
  - Latency: if the FIFO is empty when a tlast commit occurs at clock edge E, the first beat of that packet shows m_axis_tvalid=1 after edge E+2.
  - Back-to-back committed packets stream with no idle cycles while m_axis_tready=1. Sustained throughput is 1 beat/clk.
  - While m_axis_tvalid & !m_axis_tready, all m_axis outputs hold stable.
  - tvalid never drops mid-packet, because the whole packet is already stored.
  - m_axis_tuser is constant 0.
- Simultaneous events:
  - Commit and read in the same cycle are both honoured.
  - Occupancy uses rd_ptr from before the edge. A beat freed in the same cycle is not reusable until the next cycle.
  - Pointers wrap naturally modulo 2*DEPTH.
- Counters wrap silently: 0xFFFFFFFF goes to 0.

Test Plan:
- One 64-beat packet (8192 B; tkeep all ones; tdata = beat index 0..63), m_axis_tready=1 → no output before tlast is accepted. First beat appears 2 cycles after the tlast edge. 64 consecutive beats, tdata 0..63, tlast on beat 63. pkt_count=1.
- A 16-beat packet with tuser=1 on tlast, followed by a 4-beat clean packet → only the 4-beat packet is output. drop_count=1, pkt_count=1, fifo_level returns to 0.
- m_axis_tready=0, send 5 packets of 64 beats (DEPTH=256) → packets 1–4 are committed and fifo_level=256. Packet 5 is dropped entirely, drop_count=1, s_axis_tready stays 1. Then raise m_axis_tready → exactly 256 beats out, in order.
- 100 single-beat packets back-to-back, m_axis_tready toggling 1,0,1,0 → 100 beats out, each with tlast=1, data in order, stable while stalled. pkt_count=100.
- Assert rst for 1 cycle at beat 20 of a 64-beat packet → all outputs are 0 during reset. The tail of that packet (no start seen) is stored as a fragment only if it ends in tlast; the bench then sends a clean 8-beat packet and checks it is output intact and fifo_level is consistent.
- Packet of 300 beats → dropped (drop_count +1). The next 64-beat packet passes intact.
